// File: rtl/dbus_common_pkg.sv
// rtl/dbus_common_pkg.sv - shared data-bus request/response types used by core and memory models
package dbus_common_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_resp_pkg.sv
// rtl/dbus_resp_pkg.sv - responder FSM states and latency limits shared by memory responders
package dbus_resp_pkg;

  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } resp_state_e;

  // Out-of-range LATENCY values are pulled back into 1..MAX_LATENCY.
  function automatic int clamp_latency(input int lat);
    if (lat < 1) return 1;
    if (lat > MAX_LATENCY) return MAX_LATENCY;
    return lat;
  endfunction

endpackage

// File: rtl/dbus_mem_responder_if.sv
// rtl/dbus_mem_responder_if.sv - data-bus request/response bundle between core and responder
interface dbus_mem_responder_if;
  dbus_common_pkg::dbus_req_t  dreq;
  dbus_common_pkg::dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, steps when en_i is high
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'h01;
    else        lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - single-outstanding data-bus memory model with fixed latency;
// DBUS_RESP_RAND_DELAY_EN adds 0..3 LFSR-chosen wait cycles per access.
module dbus_mem_responder
  import dbus_common_pkg::*;
  import dbus_resp_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_mem_responder_if.slave  dbus,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  localparam int LAT  = clamp_latency(LATENCY);
  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  resp_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] addr_q;
  msize_t      size_q;
  logic [7:0]  strobe_q;
  logic [63:0] wdata_q;
  logic [7:0]  err_q, err_d;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic            accept;
  logic [1:0]      extra;
  logic [4:0]      wait_cycles;
  logic            rd_in_range;
  logic [IDXW-1:0] idx;
  logic            misaligned_unused;

  function automatic logic in_range(input logic [63:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 3) < 64'(DEPTH_WORDS));
  endfunction

  assign accept      = (state_q == S_IDLE) && dbus.dreq.valid;
  assign rd_in_range = in_range(addr_q);
  assign idx         = IDXW'((addr_q - BASE_ADDR) >> 3);

`ifdef DBUS_RESP_RAND_DELAY_EN
  logic [7:0] lfsr;
  logic [5:0] lfsr_hi_unused;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (accept),
    .q_o   (lfsr)
  );

  assign extra          = lfsr[1:0];
  assign lfsr_hi_unused = lfsr[7:2];
`else
  assign extra = 2'd0;
`endif

  // Total WAIT cycles; zero means the accept goes straight to RESP.
  assign wait_cycles = 5'(LAT - 1) + {3'b000, extra};

  // Size is only informative: strobe alone decides which lanes are written.
  always_comb begin
    misaligned_unused = 1'b0;
    case (size_q)
      MSIZE1:  misaligned_unused = 1'b0;
      MSIZE2:  misaligned_unused = addr_q[0];
      MSIZE4:  misaligned_unused = |addr_q[1:0];
      default: misaligned_unused = |addr_q[2:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (dbus.dreq.valid) begin
          if (wait_cycles == 5'd0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = wait_cycles - 5'd1;
          end
          if (!in_range(dbus.dreq.addr) && err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 5'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= MSIZE1;
      strobe_q <= '0;
      wdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q   <= dbus.dreq.addr;
        size_q   <= dbus.dreq.size;
        strobe_q <= dbus.dreq.strobe;
        wdata_q  <= dbus.dreq.data;
      end
    end
  end

  // Storage is deliberately left out of reset; an async reset forces IDLE so nothing commits.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && rd_in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem_q[idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

  always_comb begin
    dbus.dresp         = '0;
    dbus.dresp.addr_ok = (state_q == S_IDLE) && dbus.dreq.valid && reset;
    dbus.dresp.data_ok = (state_q == S_RESP);
    if (state_q == S_RESP && rd_in_range) dbus.dresp.data = mem_q[idx];
  end

  assign busy    = (state_q != S_IDLE);
  assign err_cnt = err_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb/tb_dbus_mem_responder.sv - self-checking bench for dbus_mem_responder against a transaction-level model
module tb_dbus_mem_responder;
  import dbus_common_pkg::*;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [7:0] err_cnt;

  dbus_mem_responder_if bus ();

  dbus_mem_responder #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .dbus    (bus.slave),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) / 64'd8) < 64'(DEPTH));
  endfunction

  // Model: word store, one pending transaction, error counter, event logs.
  logic [63:0] mm [longint unsigned];
  int          cyc = 0;
  bit          pending = 1'b0;
  int          acc_cyc = 0;
  int          due = 0;
  logic [63:0] p_addr, p_data;
  logic [7:0]  p_strb;
  int          err_m = 0;
  int          nacc = 0;
  int          ndone = 0;
  int          acc_q[$];
  int          done_q[$];
  logic [63:0] last_rdata = '0;
  bit          lat_seen [int];

  always @(negedge clk) begin
    logic             exp_aok;
    logic             done;
    int               age;
    longint unsigned  widx;
    logic [63:0]      w;
    cyc++;
    if (!reset) begin
      chk("reset_addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
      chk("reset_data_ok", 64'(bus.dresp.data_ok), 64'd0);
      chk("reset_data", bus.dresp.data, 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_err_cnt", 64'(err_cnt), 64'd0);
      pending = 1'b0;
      err_m   = 0;
    end else begin
      exp_aok = bus.dreq.valid && !pending;
      age     = cyc - acc_cyc;
      chk("addr_ok", 64'(bus.dresp.addr_ok), 64'(exp_aok));
      chk("busy", 64'(busy), 64'(pending));
      chk("err_cnt", 64'(err_cnt), 64'(err_m));
`ifdef DBUS_RESP_RAND_DELAY_EN
      if (pending && age >= LAT && age <= LAT + 3) begin
        done = bus.dresp.data_ok || (age == LAT + 3);
        if (age == LAT + 3) chk("data_ok_window", 64'(bus.dresp.data_ok), 64'd1);
      end else begin
        done = 1'b0;
        chk("data_ok", 64'(bus.dresp.data_ok), 64'd0);
      end
`else
      done = pending && (cyc == due);
      chk("data_ok", 64'(bus.dresp.data_ok), 64'(done));
`endif
      if (done) begin
        widx = (p_addr - BASE) / 64'd8;
        if (!in_rng(p_addr)) chk("rdata_out_of_range", bus.dresp.data, 64'd0);
        else if (mm.exists(widx)) chk("rdata", bus.dresp.data, mm[widx]);
        last_rdata = bus.dresp.data;
        if (in_rng(p_addr) && p_strb != 8'h00) begin
          if (mm.exists(widx)) begin
            w = mm[widx];
            for (int i = 0; i < 8; i++) if (p_strb[i]) w[i*8 +: 8] = p_data[i*8 +: 8];
            mm[widx] = w;
          end else if (p_strb == 8'hFF) begin
            mm[widx] = p_data;
          end
        end
        pending = 1'b0;
        ndone++;
        done_q.push_back(cyc);
        lat_seen[age] = 1'b1;
      end
      if (exp_aok) begin
        pending = 1'b1;
        acc_cyc = cyc;
        due     = cyc + LAT;
        p_addr  = bus.dreq.addr;
        p_data  = bus.dreq.data;
        p_strb  = bus.dreq.strobe;
        if (!in_rng(bus.dreq.addr) && err_m < 255) err_m++;
        nacc++;
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic xact(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    int n0, a0;
    n0 = ndone;
    a0 = nacc;
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = a;
    bus.dreq.size   = MSIZE8;
    bus.dreq.strobe = s;
    bus.dreq.data   = d;
    for (int i = 0; i < 40 && ndone == n0; i++) begin
      @(posedge clk); #1;
      if (nacc != a0) bus.dreq.valid = 1'b0;
    end
    bus.dreq.valid = 1'b0;
    chk("xact_completed", 64'(ndone - n0), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a0, d0, na0;
    logic [63:0] b2b [3];
    bus.dreq = '0;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("por_busy", 64'(busy), 64'd0);
    chk("por_err", 64'(err_cnt), 64'd0);
    chk("por_dresp_ok", 64'({bus.dresp.addr_ok, bus.dresp.data_ok}), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Full write then read back, with fixed-latency timing.
    a0 = acc_q.size();
    d0 = done_q.size();
    xact(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
`ifndef DBUS_RESP_RAND_DELAY_EN
    if (done_q.size() > d0 && acc_q.size() > a0) chk("write_latency", 64'(done_q[d0] - acc_q[a0]), 64'd2);
`endif
    xact(64'h8000_0010, 8'h00, 64'h0);
    chk("read_full", last_rdata, 64'h1122_3344_5566_7788);

    // Partial write returns pre-write data and merges only the low lanes.
    xact(64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
    chk("partial_prewrite", last_rdata, 64'h1122_3344_5566_7788);
    xact(64'h8000_0010, 8'h00, 64'h0);
    chk("read_partial", last_rdata, 64'h1122_3344_BBBB_BBBB);

    // First and last words of the window.
    xact(64'h8000_0000, 8'hFF, 64'hDEAD_BEEF_0123_4567);
    xact(64'h8000_7FF8, 8'hFF, 64'hCAFE_F00D_8899_AABB);
    xact(64'h8000_7FF8, 8'h00, 64'h0);
    chk("read_last_word", last_rdata, 64'hCAFE_F00D_8899_AABB);
    chk("err_in_range", 64'(err_cnt), 64'd0);

    // Reset during WAIT drops the write.
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = 64'h8000_0010;
    bus.dreq.strobe = 8'hFF;
    bus.dreq.data   = 64'h5555_5555_5555_5555;
    @(posedge clk); #1;
    bus.dreq.valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_data_ok", 64'(bus.dresp.data_ok), 64'd0);
    chk("midreset_data", bus.dresp.data, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xact(64'h8000_0010, 8'h00, 64'h0);
    chk("midreset_no_commit", last_rdata, 64'h1122_3344_BBBB_BBBB);

    // Out-of-range read below and write just past the window.
    xact(64'h7FFF_FFF8, 8'h00, 64'h0);
    chk("oor_read_zero", last_rdata, 64'd0);
    xact(64'h8000_8000, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD);
    chk("oor_write_zero", last_rdata, 64'd0);
    chk("oor_err_two", 64'(err_cnt), 64'd2);
    xact(64'h8000_0000, 8'h00, 64'h0);
    chk("oor_storage_kept", last_rdata, 64'hDEAD_BEEF_0123_4567);
    for (int i = 0; i < 298; i++) xact((i % 2 == 0) ? 64'h0000_0000 : 64'h8000_8008, 8'(i), 64'h0);
    chk("err_saturated", 64'(err_cnt), 64'hFF);

    // Valid held high across three reads.
    b2b[0] = 64'h8000_0000;
    b2b[1] = 64'h8000_0010;
    b2b[2] = 64'h8000_7FF8;
    a0  = acc_q.size();
    d0  = done_q.size();
    na0 = nacc;
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = b2b[0];
    bus.dreq.strobe = 8'h00;
    for (int i = 0; i < 60 && (done_q.size() - d0) < 3; i++) begin
      @(posedge clk); #1;
      if (nacc - na0 >= 3) bus.dreq.valid = 1'b0;
      else bus.dreq.addr = b2b[nacc - na0];
    end
    bus.dreq.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_accepts", 64'(nacc - na0), 64'd3);
    chk("b2b_done", 64'(done_q.size() - d0), 64'd3);
`ifndef DBUS_RESP_RAND_DELAY_EN
    if (done_q.size() >= d0 + 3 && acc_q.size() > a0) begin
      chk("b2b_pulse0", 64'(done_q[d0]     - acc_q[a0]), 64'd2);
      chk("b2b_pulse1", 64'(done_q[d0 + 1] - acc_q[a0]), 64'd5);
      chk("b2b_pulse2", 64'(done_q[d0 + 2] - acc_q[a0]), 64'd8);
    end
`endif
    chk("b2b_last_data", last_rdata, 64'hCAFE_F00D_8899_AABB);

`ifdef DBUS_RESP_RAND_DELAY_EN
    lat_seen.delete();
    for (int i = 0; i < 100; i++) xact(64'h8000_0000, 8'h00, 64'h0);
    chk("rand_latency_spread", 64'(lat_seen.num() >= 2), 64'd1);
    chk("rand_data", last_rdata, 64'hDEAD_BEEF_0123_4567);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_mem_responder.md
DBUS_MEM_RESPONDER -- requirements
Module: dbus_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h8000_0000, lowest byte address served.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, number of 64-bit storage words.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15, cycles from accept to data_ok.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; the polarity and synchronicity are fixed.
REQ-006 SHALL have port dreq  input  dbus_req_t  core data request (valid, addr, size, strobe, data).
REQ-007 SHALL have port dresp  output  dbus_resp_t  response (addr_ok, data_ok, data).
REQ-008 SHALL have port busy  output  1  high while a transaction is outstanding (WAIT or RESP).
REQ-009 SHALL have port err_cnt  output  8  saturating count of out-of-range accesses.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, RESP; one transaction outstanding at a time.
REQ-011 In IDLE with dreq.valid=1, the responder SHALL drive addr_ok=1 combinationally and latch addr, size, strobe and data at the edge.
REQ-012 On accept, the FSM SHALL go to RESP if LATENCY=1; otherwise it SHALL go to WAIT with down-counter = LATENCY-2 (+ extra delay, see REQ-024).
REQ-013 WAIT SHALL decrement the counter each cycle and go to RESP when the counter is 0.
REQ-014 RESP SHALL last exactly one cycle with data_ok=1, then return to IDLE; data_ok SHALL be 0 in every other cycle.
REQ-015 The accept cycle is cycle 0; data_ok SHALL be high in cycle LATENCY, measured with no extra delay.
REQ-016 Word index SHALL be (addr - BASE_ADDR) >> 3; an access SHALL be in range iff addr >= BASE_ADDR and index < DEPTH_WORDS.
REQ-017 For a read (strobe==0), dresp.data SHALL equal the full 64-bit word at the index, combinationally in RESP; the core extracts lanes.
REQ-018 For a write (strobe!=0), the responder SHALL update each byte lane i with strobe[i]=1 at the edge ending RESP; dresp.data SHALL return the pre-write word.
REQ-019 For an out-of-range access, the responder SHALL read 64'h0, discard the write, still issue data_ok, and increment err_cnt, saturating at 8'hFF.
REQ-020 addr_ok SHALL be 0 in WAIT and RESP; a dreq.valid still held in the cycle after RESP SHALL be treated as a new request.
REQ-021 A drop of dreq.valid during WAIT SHALL NOT abort the transaction; it SHALL complete and commit.
REQ-022 Inside the module, size SHALL only qualify misalignment; strobe alone governs the write.

Reset
REQ-023 When reset=0, asynchronously: state SHALL be IDLE, counter SHALL be 0, latched request SHALL be 0, dresp SHALL be all-zero, busy SHALL be 0, err_cnt SHALL be 0, and the LFSR SHALL be 8'h01; storage SHALL NOT be reset, and an outstanding transaction SHALL be dropped with no commit.

Configuration
REQ-024 With DBUS_RESP_RAND_DELAY_EN defined, each accept SHALL add 0..3 extra WAIT cycles taken from LFSR bits [1:0], and the LFSR SHALL step once per accept (LATENCY=1 then enters WAIT when extra>0).
REQ-025 Without DBUS_RESP_RAND_DELAY_EN, latency SHALL be exactly LATENCY and the LFSR logic SHALL be absent.

Structure
REQ-026 dbus_req_t, dbus_resp_t and msize_t SHALL come from the existing common package; the responder FSM state enum and a MAX_LATENCY=15 constant SHALL go in a new shared package dbus_resp_pkg.
REQ-027 The LFSR SHALL be one sub-module, lfsr8 (x^8+x^6+x^5+x^4+1, enable input), instantiated only under DBUS_RESP_RAND_DELAY_EN.
REQ-028 Storage SHALL be a DEPTH_WORDS x 64 register array with byte-lane write enables.

Verification
REQ-029 Write: addr 0x8000_0010, strobe 8'hFF, data 64'h1122_3344_5566_7788, LATENCY=2 -> addr_ok in cycle 0, data_ok only in cycle 2; a read of the same address returns 64'h1122_3344_5566_7788.
REQ-030 Partial write: strobe 8'h0F, data 64'hAAAA_AAAA_BBBB_BBBB over word 64'h1122_3344_5566_7788 -> read returns 64'h1122_3344_BBBB_BBBB.
REQ-031 Out of range: read 0x7FFF_FFF8, then write 0x8000_0000+8*DEPTH_WORDS -> both return data_ok with data 0, err_cnt=2, storage unchanged; 300 such accesses -> err_cnt=8'hFF.
REQ-032 Back-to-back: valid held high over 3 reads -> exactly 3 data_ok pulses at cycles 2, 5, 8 and no double accept.
REQ-033 Reset mid-WAIT: write accepted, reset asserted in cycle 1 -> dresp=0 and busy=0 immediately, no data_ok, target word unchanged.
REQ-034 With DBUS_RESP_RAND_DELAY_EN defined: 100 reads -> every data_ok latency is in 2..5 with at least two distinct values, and data is correct.
